alarm_tone_gen: RTL and testbench
=================================

// Module: alarm_tone_gen
// PURPOSE
//  Downstream consumer of the alarm clock's alarm_on level. Turns alarm_on into a
//  beeping square-wave tone for the piezo buzzer, with snooze, stop and auto-timeout.
//  Sits between the top-level alarm FSM and the buzzer pin.
//  All durations are counted in clk cycles.
// PARAMETERS
//  TONE_HALF   25000      cycles per tone half-period (2 kHz at 100 MHz)
//  BEEP_CYC    25000000   cycles tone is on per beep
//  GAP_CYC     25000000   cycles of silence between beeps
//  SEC_CYC     100000000  cycles per second tick
//  TIMEOUT_S   60         ring seconds before auto-stop
//  SNOOZE_S    300        snooze seconds before re-ring
//  MAX_SNOOZE  3          snoozes allowed per alarm event
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous reset, active-low
//  alarm_on     in   1  level from alarm FSM; high while alarm matches/active
//  stop         in   1  one-cycle pulse (debounced center button)
//  snooze       in   1  one-cycle pulse (debounced up/down button)
//  buzzer       out  1  tone output to piezo
//  ringing      out  1  high in RING_ON or RING_GAP
//  snoozing     out  1  high in SNOOZE
//  snooze_left  out  2  snoozes remaining (MAX_SNOOZE-used)
// BEHAVIOUR
//  Reset (rst=0 at posedge): state=IDLE, all counters 0, alarm_q=0, snooze_left=MAX_SNOOZE;
//   buzzer=ringing=snoozing=0.
//  alarm_q registers alarm_on; rise = alarm_on & ~alarm_q.
//  States: IDLE, RING_ON, RING_GAP, SNOOZE, DONE.
//   IDLE: rise -> RING_ON; phase_cnt=0, tone=1, sec_cnt=0, ring_s=0, snooze_left=MAX_SNOOZE.
//   RING_ON: tone toggles when tone_cnt reaches TONE_HALF-1; after BEEP_CYC cycles -> RING_GAP.
//   RING_GAP: buzzer 0; after GAP_CYC cycles -> RING_ON with tone=1, tone_cnt=0.
//   ring_s increments on each SEC_CYC tick in RING_ON/RING_GAP; ring_s==TIMEOUT_S -> DONE.
//   SNOOZE: snz_s counts seconds; snz_s==SNOOZE_S -> RING_ON, ring_s=0, sec_cnt=0.
//   DONE: silent; leaves to IDLE only when alarm_on==0 (no retrigger while held high).
//  Priority each cycle, highest first: alarm_on==0 (any state -> IDLE) > stop
//   (RING_*/SNOOZE -> DONE) > snooze (RING_* with snooze_left>0 -> SNOOZE,
//   snooze_left-1, snz_s=0) > timeout > beep phase change.
//  snooze pulse with snooze_left==0, or in IDLE/SNOOZE/DONE: ignored.
//  stop in IDLE/DONE: ignored.
//  buzzer = (state==RING_ON) & tone; combinational from registers, glitch-free.
//  Latency: alarm_on rising at edge k -> buzzer=1 after edge k (first cycle of RING_ON).
//  stop/snooze sampled at edge k -> buzzer=0 after edge k.
//  Counters saturate-free: each cleared on every state entry; widths = $clog2(param+1).
//  rst mid-ring: immediate return to reset values; a still-high alarm_on
//   re-rings only after a fresh rise (alarm_q resets to 0, so rise fires next cycle).
// TESTING (TONE_HALF=2, BEEP_CYC=8, GAP_CYC=8, SEC_CYC=16, TIMEOUT_S=3, SNOOZE_S=2, MAX_SNOOZE=2)
//  1 Reset held 3 cycles, alarm_on=1 -> buzzer=0, ringing=0, snooze_left=2; release -> RING_ON next cycle.
//  2 alarm_on rise -> buzzer pattern 1,1,0,0 x2 for 8 cycles then 0 for 8; repeats; DONE at cycle 48, ringing=0.
//  3 snooze pulse in RING_ON -> snoozing=1, snooze_left=1, silent 32 cycles, then RING_ON with buzzer=1.
//  4 two snoozes used, third snooze pulse -> ignored, ringing stays 1, snooze_left=0.
//  5 stop and snooze same cycle -> DONE, snooze_left unchanged; alarm_on held 1 -> stays DONE; drop -> IDLE.
//  6 alarm_on falls during RING_GAP / SNOOZE -> IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/alarm_tone_gen_if.sv
// Bundle of alarm-tone control inputs and buzzer/status outputs.
// The master side is the alarm FSM / button logic; the slave side is the tone generator.
interface alarm_tone_gen_if;
    logic       alarm_on;
    logic       stop;
    logic       snooze;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [1:0] snooze_left;

    modport master (
        output alarm_on,
        output stop,
        output snooze,
        input  buzzer,
        input  ringing,
        input  snoozing,
        input  snooze_left
    );

    modport slave (
        input  alarm_on,
        input  stop,
        input  snooze,
        output buzzer,
        output ringing,
        output snoozing,
        output snooze_left
    );
endinterface

// File: rtl/alarm_tone_gen.sv
// Alarm tone generator: converts the alarm_on level into a beeping square wave
// for the piezo buzzer, with snooze (limited count), stop and ring auto-timeout.
// All durations are in clk cycles. Every output is a flop, so the buzzer pin is glitch-free.
module alarm_tone_gen #(
    parameter int TONE_HALF  = 25000,
    parameter int BEEP_CYC   = 25000000,
    parameter int GAP_CYC    = 25000000,
    parameter int SEC_CYC    = 100000000,
    parameter int TIMEOUT_S  = 60,
    parameter int SNOOZE_S   = 300,
    parameter int MAX_SNOOZE = 3
) (
    input  logic            clk,
    input  logic            rst,
    alarm_tone_gen_if.slave bus
);

    localparam int PH_MAX = (BEEP_CYC > GAP_CYC) ? BEEP_CYC : GAP_CYC;
    localparam int PW     = $clog2(PH_MAX + 1);
    localparam int TW     = $clog2(TONE_HALF + 1);
    localparam int SW     = $clog2(SEC_CYC + 1);
    localparam int RW     = $clog2(TIMEOUT_S + 1);
    localparam int ZW     = $clog2(SNOOZE_S + 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RING_ON  = 3'd1;
    localparam logic [2:0] ST_RING_GAP = 3'd2;
    localparam logic [2:0] ST_SNOOZE   = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    localparam logic [PW-1:0] BEEP_LAST = PW'(BEEP_CYC - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_CYC - 1);
    localparam logic [PW-1:0] PH_ONE    = PW'(1);
    localparam logic [TW-1:0] TONE_LAST = TW'(TONE_HALF - 1);
    localparam logic [TW-1:0] TONE_ONE  = TW'(1);
    localparam logic [SW-1:0] SEC_LAST  = SW'(SEC_CYC - 1);
    localparam logic [SW-1:0] SEC_ONE   = SW'(1);
    localparam logic [RW-1:0] RING_LAST = RW'(TIMEOUT_S - 1);
    localparam logic [RW-1:0] RING_ONE  = RW'(1);
    localparam logic [ZW-1:0] SNZ_LAST  = ZW'(SNOOZE_S - 1);
    localparam logic [ZW-1:0] SNZ_ONE   = ZW'(1);
    localparam logic [1:0]    SL_MAX    = 2'(MAX_SNOOZE);

    // Registered state
    logic [2:0]    state_r;
    logic          alarm_q_r;
    logic [PW-1:0] phase_cnt_r;
    logic [TW-1:0] tone_cnt_r;
    logic          tone_r;
    logic [SW-1:0] sec_cnt_r;
    logic [RW-1:0] ring_s_r;
    logic [ZW-1:0] snz_s_r;
    logic [1:0]    snooze_left_r;
    logic          buzzer_r;
    logic          ringing_r;
    logic          snoozing_r;

    // Next-state values
    logic [2:0]    state_next_s;
    logic [PW-1:0] phase_next_s;
    logic [TW-1:0] tone_cnt_next_s;
    logic          tone_next_s;
    logic [SW-1:0] sec_next_s;
    logic [RW-1:0] ring_s_next_s;
    logic [ZW-1:0] snz_s_next_s;
    logic [1:0]    snooze_left_next_s;
    logic          clr_s;
    logic          ring_entry_s;
    logic          rise_s;
    logic          sec_tick_s;

    // Edge detect on the alarm level and one-second tick decode
    always_comb begin
        rise_s     = bus.alarm_on & ~alarm_q_r;
        sec_tick_s = (sec_cnt_r == SEC_LAST);
    end

    // State transitions in priority order: alarm drop > stop > snooze > timeout > beep phase
    always_comb begin
        state_next_s       = state_r;
        phase_next_s       = phase_cnt_r;
        tone_cnt_next_s    = tone_cnt_r;
        tone_next_s        = tone_r;
        sec_next_s         = sec_cnt_r;
        ring_s_next_s      = ring_s_r;
        snz_s_next_s       = snz_s_r;
        snooze_left_next_s = snooze_left_r;
        clr_s              = 1'b0;
        ring_entry_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_next_s       = ST_RING_ON;
                    clr_s              = 1'b1;
                    ring_entry_s       = 1'b1;
                    snooze_left_next_s = SL_MAX;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end

            ST_RING_ON, ST_RING_GAP: begin
                if (!bus.alarm_on) begin
                    state_next_s = ST_IDLE;
                    clr_s        = 1'b1;
                end else if (bus.stop) begin
                    state_next_s = ST_DONE;
                    clr_s        = 1'b1;
                end else if (bus.snooze && (snooze_left_r != 2'd0)) begin
                    state_next_s       = ST_SNOOZE;
                    clr_s              = 1'b1;
                    snooze_left_next_s = snooze_left_r - 2'd1;
                end else if (sec_tick_s && (ring_s_r == RING_LAST)) begin
                    // Final ring second elapses on this edge
                    state_next_s = ST_DONE;
                    clr_s        = 1'b1;
                end else begin
                    // Ring-second bookkeeping continues across beep and gap
                    if (sec_tick_s) begin
                        sec_next_s    = '0;
                        ring_s_next_s = ring_s_r + RING_ONE;
                    end else begin
                        sec_next_s    = sec_cnt_r + SEC_ONE;
                        ring_s_next_s = ring_s_r;
                    end

                    if (state_r == ST_RING_ON) begin
                        if (phase_cnt_r == BEEP_LAST) begin
                            state_next_s    = ST_RING_GAP;
                            phase_next_s    = '0;
                            tone_cnt_next_s = '0;
                        end else begin
                            phase_next_s = phase_cnt_r + PH_ONE;
                            if (tone_cnt_r == TONE_LAST) begin
                                tone_next_s     = ~tone_r;
                                tone_cnt_next_s = '0;
                            end else begin
                                tone_cnt_next_s = tone_cnt_r + TONE_ONE;
                            end
                        end
                    end else begin
                        if (phase_cnt_r == GAP_LAST) begin
                            // Each beep restarts with the tone high
                            state_next_s    = ST_RING_ON;
                            phase_next_s    = '0;
                            tone_cnt_next_s = '0;
                            tone_next_s     = 1'b1;
                        end else begin
                            phase_next_s = phase_cnt_r + PH_ONE;
                        end
                    end
                end
            end

            ST_SNOOZE: begin
                if (!bus.alarm_on) begin
                    state_next_s = ST_IDLE;
                    clr_s        = 1'b1;
                end else if (bus.stop) begin
                    state_next_s = ST_DONE;
                    clr_s        = 1'b1;
                end else if (sec_tick_s && (snz_s_r == SNZ_LAST)) begin
                    state_next_s = ST_RING_ON;
                    clr_s        = 1'b1;
                    ring_entry_s = 1'b1;
                end else begin
                    if (sec_tick_s) begin
                        sec_next_s   = '0;
                        snz_s_next_s = snz_s_r + SNZ_ONE;
                    end else begin
                        sec_next_s   = sec_cnt_r + SEC_ONE;
                        snz_s_next_s = snz_s_r;
                    end
                end
            end

            ST_DONE: begin
                // Held alarm level must drop before a new alarm can ring
                if (!bus.alarm_on) begin
                    state_next_s = ST_IDLE;
                    clr_s        = 1'b1;
                end else begin
                    state_next_s = ST_DONE;
                end
            end

            default: begin
                state_next_s = ST_IDLE;
                clr_s        = 1'b1;
            end
        endcase

        // Every state entry starts all counters from zero; ringing starts with tone high
        if (clr_s) begin
            phase_next_s    = '0;
            tone_cnt_next_s = '0;
            sec_next_s      = '0;
            ring_s_next_s   = '0;
            snz_s_next_s    = '0;
            tone_next_s     = ring_entry_s;
        end else begin
            tone_next_s = tone_next_s;
        end
    end

    // State, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            alarm_q_r     <= 1'b0;
            phase_cnt_r   <= '0;
            tone_cnt_r    <= '0;
            tone_r        <= 1'b0;
            sec_cnt_r     <= '0;
            ring_s_r      <= '0;
            snz_s_r       <= '0;
            snooze_left_r <= SL_MAX;
            buzzer_r      <= 1'b0;
            ringing_r     <= 1'b0;
            snoozing_r    <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            alarm_q_r     <= bus.alarm_on;
            phase_cnt_r   <= phase_next_s;
            tone_cnt_r    <= tone_cnt_next_s;
            tone_r        <= tone_next_s;
            sec_cnt_r     <= sec_next_s;
            ring_s_r      <= ring_s_next_s;
            snz_s_r       <= snz_s_next_s;
            snooze_left_r <= snooze_left_next_s;
            buzzer_r      <= (state_next_s == ST_RING_ON) & tone_next_s;
            ringing_r     <= (state_next_s == ST_RING_ON) | (state_next_s == ST_RING_GAP);
            snoozing_r    <= (state_next_s == ST_SNOOZE);
        end
    end

    assign bus.buzzer      = buzzer_r;
    assign bus.ringing     = ringing_r;
    assign bus.snoozing    = snoozing_r;
    assign bus.snooze_left = snooze_left_r;

endmodule

// File: tb/tb_alarm_tone_gen.sv
// Scoreboard bench for alarm_tone_gen with small timing parameters.
// Stimulus is applied on the falling edge and the expected post-edge outputs are queued;
// a monitor pops one expectation after each rising edge and compares.
module tb_alarm_tone_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alarm_tone_gen_if bus();

    alarm_tone_gen #(
        .TONE_HALF (2),
        .BEEP_CYC  (8),
        .GAP_CYC   (8),
        .SEC_CYC   (16),
        .TIMEOUT_S (3),
        .SNOOZE_S  (2),
        .MAX_SNOOZE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       buz;
        logic       ring;
        logic       snzg;
        logic [1:0] sl;
        bit         chk_sl;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk1(input string tag, input string what, input logic act, input logic expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %0b expected %0b at %0t", tag, what, act, expv, $time);
        end
    endtask

    task automatic chk2(input string tag, input string what, input logic [1:0] act, input logic [1:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %0d expected %0d at %0t", tag, what, act, expv, $time);
        end
    endtask

    // Beep pattern n cycles after ring start: 1,1,0,0 twice over 8 cycles, then 8 silent
    function automatic logic exp_buz(input int n);
        return (((n / 8) % 2) == 0) && ((n % 4) < 2);
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge
    task automatic step(input logic r, input logic a, input logic st, input logic sn,
                        input string tag, input logic buz, input logic ring, input logic snzg,
                        input logic [1:0] sl, input bit chk_sl);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.alarm_on = a;
        bus.stop     = st;
        bus.snooze   = sn;
        e.tag    = tag;
        e.buz    = buz;
        e.ring   = ring;
        e.snzg   = snzg;
        e.sl     = sl;
        e.chk_sl = chk_sl;
        exp_q.push_back(e);
    endtask

    task automatic ring_cycles(input int from, input int to, input string tag, input logic [1:0] sl);
        for (int n = from; n <= to; n++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, tag, exp_buz(n), 1'b1, 1'b0, sl, 1'b1);
        end
    endtask

    task automatic snz_cycles(input int cnt, input string tag, input logic [1:0] sl);
        for (int i = 0; i < cnt; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, tag, 1'b0, 1'b0, 1'b1, sl, 1'b1);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation after each edge
    always begin
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk1(mon_e.tag, "buzzer", bus.buzzer, mon_e.buz);
            chk1(mon_e.tag, "ringing", bus.ringing, mon_e.ring);
            chk1(mon_e.tag, "snoozing", bus.snoozing, mon_e.snzg);
            if (mon_e.chk_sl) begin
                chk2(mon_e.tag, "snooze_left", bus.snooze_left, mon_e.sl);
            end
        end
    end

    initial begin
        bus.alarm_on = 1'b0;
        bus.stop     = 1'b0;
        bus.snooze   = 1'b0;
        rst          = 1'b0;

        // 1: reset held with alarm high, then release rings next cycle
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, "rst_hold", 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
        end
        step(1'b1, 1'b1, 1'b0, 1'b0, "rst_rel", 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);

        // 2: full beep pattern until timeout, DONE holds while alarm high, drop -> IDLE
        ring_cycles(1, 47, "t2_ring", 2'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t2_done", 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t2_done_held", 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t2_done_held", 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, "t2_idle", 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, "idle_stop", 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b1, "idle_snooze", 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);

        // 3: snooze in RING_ON, 32 silent cycles, then ring again
        step(1'b1, 1'b1, 1'b0, 1'b0, "t3_rise", 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t3_c1", 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, "t3_snz", 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        snz_cycles(31, "t3_snoozing", 2'd1);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t3_rering", 1'b1, 1'b1, 1'b0, 2'd1, 1'b1);

        // 4: second snooze used, third ignored
        step(1'b1, 1'b1, 1'b0, 1'b1, "t4_snz2", 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
        snz_cycles(31, "t4_snoozing", 2'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t4_rering", 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, "t4_snz3_ign", 1'b1, 1'b1, 1'b0, 2'd0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t4_c2", 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);

        // 5: stop and snooze together -> DONE, snooze count untouched
        step(1'b1, 1'b0, 1'b0, 1'b0, "t5_drop", 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t5_rise", 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, "t5_stop_snz", 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, "t5_done_held", 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0, 1'b0, "t5_idle", 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);

        // 6: alarm drop during RING_GAP and during SNOOZE
        step(1'b1, 1'b1, 1'b0, 1'b0, "t6_rise", 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
        ring_cycles(1, 9, "t6_ring", 2'd2);
        step(1'b1, 1'b0, 1'b0, 1'b0, "t6_gap_drop", 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, "t6_rise2", 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, "t6_snz", 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        snz_cycles(3, "t6_snoozing", 2'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, "t6_snz_drop", 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);

        // Reset in the middle of a snooze, alarm still high: re-rings right after release
        step(1'b1, 1'b1, 1'b0, 1'b0, "rm_rise", 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, "rm_snz", 1'b0, 1'b0, 1'b1, 2'd1, 1'b1);
        snz_cycles(2, "rm_snoozing", 2'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0, "rm_rst", 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, "rm_rering", 1'b1, 1'b1, 1'b0, 2'd2, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, "rm_drop", 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
        end
        #2;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
